// File: rtl/leaf_user_tx_port.sv
// leaf_user_tx_port: kernel-to-leaf-interface word FIFO with registered FWFT output and debug counters
module leaf_user_tx_port #(
  parameter int PAYLOAD_BITS   = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int CNT_BITS       = 32
) (
  input  logic                      clk_user,
  input  logic                      reset,
  input  logic [PAYLOAD_BITS-1:0]   s_din,
  input  logic                      s_vld,
  output logic                      s_rdy,
  output logic [PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  output logic                      vld_user2interface,
  input  logic                      ack_interface2user,
  output logic [FIFO_ADDR_BITS:0]   fifo_count,
  output logic [CNT_BITS-1:0]       words_sent
);
  logic [PAYLOAD_BITS-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr, rd_n;
  logic [FIFO_ADDR_BITS:0]   count, count_n;
  logic [PAYLOAD_BITS-1:0]   din_n;
  logic                      push, pop;
  assign push = s_vld && s_rdy;
  assign pop = vld_user2interface && ack_interface2user;
  assign rd_n = rd_ptr + FIFO_ADDR_BITS'(pop);
  assign count_n = count + (FIFO_ADDR_BITS+1)'(push) - (FIFO_ADDR_BITS+1)'(pop);
  assign fifo_count = count;
  // a word written this edge into the next head slot is not in mem yet, so take it from s_din
  always_comb
    din_n = (count_n == '0) ? din_leaf_user2interface :
            (push && wr_ptr == rd_n) ? s_din : mem[rd_n];
  always_ff @(posedge clk_user)
    if (push && !reset) mem[wr_ptr] <= s_din;
  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      vld_user2interface      <= 1'b0;
      din_leaf_user2interface <= '0;
      words_sent              <= '0;
      s_rdy                   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_BITS'(1);
      rd_ptr                  <= rd_n;
      count                   <= count_n;
      vld_user2interface      <= count_n != '0;
      din_leaf_user2interface <= din_n;
      if (pop) words_sent <= words_sent + CNT_BITS'(1);
      s_rdy                   <= count_n != (FIFO_ADDR_BITS+1)'(FIFO_DEPTH);
    end
  end
endmodule

// File: tb/tb_leaf_user_tx_port.sv
// tb_leaf_user_tx_port: directed and random checks of leaf_user_tx_port against a queue model
module tb_leaf_user_tx_port;
  logic        clk_user = 0;
  logic        reset = 1;
  logic [31:0] s_din = 0;
  logic        s_vld = 0;
  logic        s_rdy;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user = 0;
  logic [4:0]  fifo_count;
  logic [31:0] words_sent;
  int          n_pass = 0, n_total = 0;

  leaf_user_tx_port dut (
    .clk_user(clk_user), .reset(reset), .s_din(s_din), .s_vld(s_vld), .s_rdy(s_rdy),
    .din_leaf_user2interface(din_leaf_user2interface), .vld_user2interface(vld_user2interface),
    .ack_interface2user(ack_interface2user), .fifo_count(fifo_count), .words_sent(words_sent)
  );

  initial forever #5 clk_user = ~clk_user;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Model: a queue of buffered words; head is what the interface sees
  logic [31:0] q[$];
  logic [31:0] m_sent, m_din;
  bit          m_rdy, m_vld, mv, m_pop, m_push;
  initial forever begin
    @(negedge clk_user);
    if (mv) begin
      chk("s_rdy", 32'(s_rdy), 32'(m_rdy));
      chk("vld", 32'(vld_user2interface), 32'(m_vld));
      chk("din", din_leaf_user2interface, m_din);
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("words_sent", words_sent, m_sent);
    end
    if (reset) begin
      q.delete();
      m_sent = 0; m_rdy = 0; m_vld = 0; m_din = 0; mv = 1;
    end else if (mv) begin
      m_pop = m_vld && ack_interface2user;
      m_push = s_vld && m_rdy;
      if (m_pop) begin
        void'(q.pop_front());
        m_sent++;
      end
      if (m_push) q.push_back(s_din);
      m_vld = q.size() > 0;
      if (m_vld) m_din = q[0];
      m_rdy = q.size() < 16;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_user);
    #2;
  endtask

  task automatic reset_dut(input int n);
    reset = 1; s_vld = 0; ack_interface2user = 0;
    cyc(n);
    reset = 0;
    cyc(1);
  endtask

  initial begin
    // reset then single word
    reset_dut(3);
    chk("rdy_after_reset", 32'(s_rdy), 32'd1);
    s_din = 32'hDEADBEEF; s_vld = 1; ack_interface2user = 1;
    cyc(1);
    s_vld = 0;
    chk("single_vld", 32'(vld_user2interface), 32'd1);
    chk("single_din", din_leaf_user2interface, 32'hDEADBEEF);
    cyc(1);
    chk("single_vld_after_pop", 32'(vld_user2interface), 32'd0);
    chk("single_sent", words_sent, 32'd1);
    chk("single_count", 32'(fifo_count), 32'd0);

    // backpressure hold
    reset_dut(1);
    for (int i = 1; i <= 4; i++) begin
      s_din = 32'(i); s_vld = 1;
      cyc(1);
    end
    s_vld = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_din", din_leaf_user2interface, 32'd1);
      cyc(1);
    end
    ack_interface2user = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_din", din_leaf_user2interface, 32'(i));
      cyc(1);
    end
    ack_interface2user = 0;
    chk("bp_sent", words_sent, 32'd4);

    // fill to full, then a single ack pulse
    reset_dut(1);
    s_vld = 1;
    for (int i = 0; i < 20; i++) begin
      s_din = 32'(100 + i);
      cyc(1);
    end
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_rdy", 32'(s_rdy), 32'd0);
    chk("full_head", din_leaf_user2interface, 32'd100);
    s_din = 32'd200; ack_interface2user = 1;
    cyc(1);
    ack_interface2user = 0;
    chk("pulse_rdy", 32'(s_rdy), 32'd1);
    chk("pulse_count", 32'(fifo_count), 32'd15);
    s_din = 32'd201;
    cyc(1);
    s_vld = 0;
    chk("refill_count", 32'(fifo_count), 32'd16);
    ack_interface2user = 1;
    cyc(16);
    ack_interface2user = 0;
    chk("full_sent", words_sent, 32'd17);

    // steady-state simultaneous push/pop
    reset_dut(1);
    s_vld = 1;
    for (int i = 0; i < 5; i++) begin
      s_din = 32'(300 + i);
      cyc(1);
    end
    ack_interface2user = 1;
    for (int i = 0; i < 40; i++) begin
      s_din = 32'(400 + i);
      cyc(1);
      chk("steady_count", 32'(fifo_count), 32'd5);
    end
    s_vld = 0;
    cyc(5);
    ack_interface2user = 0;
    chk("steady_sent", words_sent, 32'd45);

    // reset mid-operation with 7 words buffered
    reset_dut(1);
    s_vld = 1;
    for (int i = 0; i < 9; i++) begin
      s_din = 32'(500 + i);
      cyc(1);
    end
    s_vld = 0; ack_interface2user = 1;
    cyc(2);
    ack_interface2user = 0;
    chk("pre_reset_count", 32'(fifo_count), 32'd7);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("mid_reset_vld", 32'(vld_user2interface), 32'd0);
    chk("mid_reset_count", 32'(fifo_count), 32'd0);
    chk("mid_reset_sent", words_sent, 32'd0);
    cyc(1);
    chk("mid_reset_rdy", 32'(s_rdy), 32'd1);
    s_din = 32'hA5A5A5A5; s_vld = 1;
    cyc(1);
    s_vld = 0;
    chk("post_reset_din", din_leaf_user2interface, 32'hA5A5A5A5);
    chk("post_reset_vld", 32'(vld_user2interface), 32'd1);

    // random stress
    for (int i = 0; i < 10000; i++) begin
      s_vld = 1'($urandom_range(1));
      ack_interface2user = 1'($urandom_range(1));
      s_din = $urandom;
      cyc(1);
    end
    s_vld = 0; ack_interface2user = 1;
    cyc(20);
    chk("stress_drained", 32'(fifo_count), 32'd0);
    @(negedge clk_user);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
